// File: rtl/qspi_ram_device.sv
// Word-level front end to an SPI mode-0 serial SRAM: turns cache read/write/address
// requests into CMD/ADDR/DATA frames on io0/io1, streaming sequential words while possible.
module qspi_ram_device #(
  parameter int INIT_DELAY      = 256,
  parameter int DESELECT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  clockScale,
  input  logic        qspi_enable,
  input  logic        qspi_interruptOperation,
  input  logic [23:0] qspi_address,
  input  logic        qspi_changeAddress,
  input  logic        qspi_requestData,
  input  logic        qspi_storeData,
  input  logic [31:0] qspi_writeData,
  output logic [31:0] qspi_readData,
  output logic        qspi_wordComplete,
  output logic        qspi_initialised,
  output logic        qspi_busy,
  output logic        device_csb,
  output logic        device_sck,
  output logic        device_io0_we,
  output logic        device_io0_write,
  input  logic        device_io0_read,
  output logic        device_io1_we,
  output logic        device_io1_write,
  input  logic        device_io1_read
);

  typedef enum logic [2:0] {
    S_DISABLED, S_INIT_WAIT, S_IDLE, S_CMD, S_ADDR, S_DATA, S_HOLD, S_DESELECT
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  div_q, div_d;
  logic [3:0]  scale_q, scale_d;
  logic [5:0]  bit_q, bit_d;
  logic        sck_q, sck_d;
  logic        csb_q, csb_d;
  logic        io0_q, io0_d;
  logic [23:0] addr_q, addr_d;
  logic [23:0] xaddr_q, xaddr_d;
  logic        pend_q, pend_d;
  logic        dir_q, dir_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wc_q, wc_d;
  logic        init_q, init_d;

  logic        req_any, req_dir, go_desel;
  logic [5:0]  bit_nx;
  logic [63:0] frame;
  logic        unused_io0;

  assign unused_io0 = device_io0_read;
  assign req_any    = qspi_requestData | qspi_storeData;
  // dir: 1 = write; a simultaneous read request takes priority
  assign req_dir    = ~qspi_requestData;
  assign bit_nx     = bit_q + 6'd1;

  // Whole transaction as it appears on io0; bit n of the wire is frame[63-n] == frame[~n]
  always_comb begin
    frame = {dir_q ? 8'h02 : 8'h03, xaddr_q,
             dir_q ? {wdata_q[7:0], wdata_q[15:8], wdata_q[23:16], wdata_q[31:24]} : 32'h0};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    scale_d  = scale_q;
    bit_d    = bit_q;
    sck_d    = sck_q;
    csb_d    = csb_q;
    io0_d    = io0_q;
    addr_d   = addr_q;
    xaddr_d  = xaddr_q;
    pend_d   = pend_q;
    dir_d    = dir_q;
    wdata_d  = wdata_q;
    rx_d     = rx_q;
    rdata_d  = rdata_q;
    wc_d     = 1'b0;
    init_d   = init_q;
    go_desel = 1'b0;

    if (qspi_changeAddress) begin
      addr_d = {qspi_address[23:2], 2'b00};
      pend_d = 1'b1;
    end

    if (!qspi_enable) begin
      state_d = S_DISABLED;
      csb_d   = 1'b1;
      sck_d   = 1'b0;
      io0_d   = 1'b0;
      div_d   = '0;
      init_d  = 1'b0;
    end else begin
      case (state_q)
        S_DISABLED: begin
          state_d = S_INIT_WAIT;
          cnt_d   = '0;
        end
        S_INIT_WAIT: begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q >= 16'(INIT_DELAY - 2)) begin
            state_d = S_IDLE;
            init_d  = 1'b1;
          end
        end
        S_IDLE: begin
          if (req_any) begin
            state_d = S_CMD;
            dir_d   = req_dir;
            wdata_d = qspi_writeData;
            scale_d = clockScale;
            xaddr_d = addr_d;
            pend_d  = 1'b0;
            csb_d   = 1'b0;
            sck_d   = 1'b0;
            div_d   = '0;
            bit_d   = '0;
            io0_d   = 1'b0;
          end
        end
        S_CMD, S_ADDR, S_DATA: begin
          if (qspi_interruptOperation) begin
            go_desel = 1'b1;
          end else if (div_q != scale_q) begin
            div_d = div_q + 4'd1;
          end else begin
            div_d = '0;
            if (!sck_q) begin
              sck_d = 1'b1;
              if (state_q == S_DATA && !dir_q) rx_d = {rx_q[30:0], device_io1_read};
            end else begin
              sck_d = 1'b0;
              bit_d = bit_nx;
              io0_d = frame[~bit_nx];
              if (bit_q == 6'd7) begin
                state_d = S_ADDR;
              end else if (bit_q == 6'd31) begin
                state_d = S_DATA;
              end else if (bit_q == 6'd63) begin
                state_d = S_HOLD;
                wc_d    = 1'b1;
                io0_d   = 1'b0;
                if (!dir_q) rdata_d = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
                // A new address latched during the word wins over the increment
                if (!pend_q && !qspi_changeAddress) begin
                  addr_d = addr_q + 24'd4;
                  if (addr_q == 24'hFFFFFC) pend_d = 1'b1;
                end
              end
            end
          end
        end
        S_HOLD: begin
          if (qspi_interruptOperation || pend_q || qspi_changeAddress) begin
            go_desel = 1'b1;
          end else if (req_any) begin
            if (req_dir != dir_q) begin
              go_desel = 1'b1;
            end else begin
              state_d = S_DATA;
              wdata_d = qspi_writeData;
              bit_d   = 6'd32;
              div_d   = '0;
              sck_d   = 1'b0;
              io0_d   = req_dir ? qspi_writeData[7] : 1'b0;
            end
          end
        end
        S_DESELECT: begin
          cnt_d = cnt_q + 16'd1;
          // The IDLE cycle that follows also keeps csb high, completing the minimum gap
          if (cnt_q >= 16'(DESELECT_CYCLES - 2)) state_d = S_IDLE;
        end
        default: state_d = S_DISABLED;
      endcase
    end

    if (go_desel) begin
      state_d = S_DESELECT;
      cnt_d   = '0;
      csb_d   = 1'b1;
      sck_d   = 1'b0;
      io0_d   = 1'b0;
      div_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_DISABLED;
      cnt_q   <= '0;
      div_q   <= '0;
      scale_q <= '0;
      bit_q   <= '0;
      sck_q   <= 1'b0;
      csb_q   <= 1'b1;
      io0_q   <= 1'b0;
      addr_q  <= '0;
      xaddr_q <= '0;
      pend_q  <= 1'b0;
      dir_q   <= 1'b0;
      wdata_q <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      wc_q    <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      scale_q <= scale_d;
      bit_q   <= bit_d;
      sck_q   <= sck_d;
      csb_q   <= csb_d;
      io0_q   <= io0_d;
      addr_q  <= addr_d;
      xaddr_q <= xaddr_d;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      wdata_q <= wdata_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      wc_q    <= wc_d;
      init_q  <= init_d;
    end
  end

  assign qspi_readData     = rdata_q;
  assign qspi_wordComplete = wc_q;
  assign qspi_initialised  = init_q;
  assign qspi_busy         = state_q inside {S_INIT_WAIT, S_CMD, S_ADDR, S_DATA, S_DESELECT};
  assign device_csb        = csb_q;
  assign device_sck        = sck_q;
  assign device_io0_we     = ~csb_q;
  assign device_io0_write  = io0_q;
  assign device_io1_we     = 1'b0;
  assign device_io1_write  = 1'b0;

endmodule
